// File: rtl/gcd_pkg.sv
// Shared types and defaults for the subtractive-Euclid GCD sequencer.
package gcd_pkg;

    localparam int GCD_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/CLADiff.sv
// Absolute-difference unit: R = |A - B|, COUT = 1 when A >= B.
module CLADiff #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] R,
    output logic         COUT
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;
    logic [N-1:0] sum;

    // A + ~B + 1 with generate/propagate carries; the final carry is the A >= B flag.
    always_comb begin
        gen      = A & ~B;
        prop     = A ^ ~B;
        carry    = '0;
        carry[0] = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum  = prop ^ carry[N-1:0];
        COUT = carry[N];
        R    = COUT ? sum : (~sum + N'(1));
    end

endmodule

// File: rtl/gcd_sequencer.sv
// Iterative subtractive-Euclid GCD engine with START/BUSY/DONE handshake.
// Optional subtract-step counter and STEPS port enabled by GCD_STEP_COUNT_EN.
module gcd_sequencer
    import gcd_pkg::*;
#(
    parameter int N = GCD_DEFAULT_N
`ifdef GCD_STEP_COUNT_EN
  , parameter int CW = 2*N
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          START,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    output logic          BUSY,
    output logic          DONE,
    output logic [N-1:0]  RESULT
`ifdef GCD_STEP_COUNT_EN
  , output logic [CW-1:0] STEPS
`endif
);

    gcd_state_t   state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] result_q, result_d;
    logic [N-1:0] diff;
    logic         a_ge_b;
`ifdef GCD_STEP_COUNT_EN
    logic [CW-1:0] steps_q, steps_d;
`endif

    CLADiff #(.N(N)) u_diff (
        .A    (a_q),
        .B    (b_q),
        .R    (diff),
        .COUT (a_ge_b)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        BUSY     = 1'b0;
        DONE     = 1'b0;
`ifdef GCD_STEP_COUNT_EN
        steps_d  = steps_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
`ifdef GCD_STEP_COUNT_EN
                    steps_d = '0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                // Termination tests look only at the registers, keeping CLADiff off the decision path.
                if (a_q == '0) begin
                    result_d = b_q;
                    state_d  = FIN;
                end else if (b_q == '0) begin
                    result_d = a_q;
                    state_d  = FIN;
                end else if (a_q == b_q) begin
                    result_d = a_q;
                    state_d  = FIN;
                end else begin
                    if (a_ge_b) begin
                        a_d = diff;
                    end else begin
                        b_d = diff;
                    end
`ifdef GCD_STEP_COUNT_EN
                    if (steps_q != '1) begin
                        steps_d = steps_q + CW'(1);
                    end
`endif
                end
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
`ifdef GCD_STEP_COUNT_EN
            steps_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
`ifdef GCD_STEP_COUNT_EN
            steps_q  <= steps_d;
`endif
        end
    end

    assign RESULT = result_q;
`ifdef GCD_STEP_COUNT_EN
    assign STEPS  = steps_q;
`endif

endmodule

// File: tb/tb_gcd_sequencer.sv
// Randomized self-checking bench for gcd_sequencer against a division-based Euclid model.
module tb_gcd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       START;
    logic [7:0] A;
    logic [7:0] B;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
`ifdef GCD_STEP_COUNT_EN
    logic [15:0] STEPS;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    gcd_sequencer #(.N(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .START  (START),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
`ifdef GCD_STEP_COUNT_EN
      , .STEPS  (STEPS)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Subtraction count equals the sum of Euclid quotients minus the final one that lands on equality.
    function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned s);
        int unsigned x, y, r;
        s = 0;
        if (a == 0) begin
            g = b;
        end else if (b == 0) begin
            g = a;
        end else begin
            x = (a > b) ? a : b;
            y = (a > b) ? b : a;
            while (y != 0) begin
                s += x / y;
                r  = x % y;
                x  = y;
                y  = r;
            end
            g = x;
            s = s - 1;
        end
    endfunction

    task automatic check_idle(input string tag, input int unsigned exp_res);
        check_eq({tag, "_busy"}, BUSY, 0);
        check_eq({tag, "_done"}, DONE, 0);
        check_eq({tag, "_result"}, RESULT, exp_res);
`ifdef GCD_STEP_COUNT_EN
        check_eq({tag, "_steps"}, STEPS, 0);
`endif
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit inj_busy, input bit inj_fin);
        int unsigned exp_g, exp_s, j, bad, spurious;
        logic [7:0]  prev_res;
        bit          seen;
        ref_gcd(a, b, exp_g, exp_s);
        prev_res = RESULT;
        @(negedge clk);
        START = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        START = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
        j     = 1;
        bad   = 0;
        seen  = 1'b0;
        while (j <= 600) begin
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            if (!BUSY || RESULT != prev_res) bad++;
            if (inj_busy && j == 5) begin
                START = 1'b1;
                A     = 8'($urandom_range(1, 255));
                B     = 8'($urandom_range(1, 255));
            end
            if (j == 6) START = 1'b0;
            @(negedge clk);
            j++;
        end
        check_eq("done_seen", seen, 1);
        check_eq("busy_hold_during_run", bad, 0);
        check_eq("latency", j, exp_s + 2);
        check_eq("busy_at_done", BUSY, 0);
        check_eq("result", RESULT, exp_g);
`ifdef GCD_STEP_COUNT_EN
        check_eq("steps", STEPS, (exp_s > 65535) ? 65535 : exp_s);
`endif
        if (inj_fin) begin
            START = 1'b1;
            A     = 8'd9;
            B     = 8'd6;
        end
        @(negedge clk);
        START = 1'b0;
        check_eq("done_one_cycle", DONE, 0);
        check_eq("idle_after_fin", BUSY, 0);
        check_eq("result_held", RESULT, exp_g);
        spurious = 0;
        repeat (3) begin
            @(negedge clk);
            if (DONE || BUSY || RESULT != exp_g) spurious++;
        end
        check_eq("quiet_after_fin", spurious, 0);
    endtask

    initial begin
        int unsigned bad;
        logic [7:0]  ra, rb;
        rst_n = 1'b0;
        START = 1'b1;
        A     = 8'd5;
        B     = 8'd5;

        // Reset held with START asserted: nothing may start.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_idle("reset", 0);
        end
        START = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset", 0);

        run_op(8'd12, 8'd18, 1'b0, 1'b0);
        run_op(8'd0,  8'd45, 1'b0, 1'b0);
        run_op(8'd0,  8'd0,  1'b0, 1'b0);
        run_op(8'd200, 8'd0, 1'b0, 1'b0);
        run_op(8'd1, 8'd255, 1'b1, 1'b1);

        // Reset partway through a long run.
        @(negedge clk);
        START = 1'b1;
        A     = 8'd1;
        B     = 8'd255;
        @(negedge clk);
        START = 1'b0;
        bad   = 0;
        repeat (50) begin
            if (!BUSY || DONE) bad++;
            @(negedge clk);
        end
        check_eq("midop_running", bad, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("midop_reset", 0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (DONE || BUSY) bad++;
        end
        check_eq("midop_no_done", bad, 0);
        run_op(8'd48, 8'd36, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ((i % 6) == 0) ra = 8'd0;
            if ((i % 6) == 3) rb = 8'd0;
            if ((i % 6) == 4) rb = ra;
            run_op(ra, rb, (i % 2) == 1, (i % 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
